// File: rtl/alu_seq_if.sv
// alu_seq_if: instruction handshake and register-bus bundle; master drives instr/bus responses, slave is alu_seq
interface alu_seq_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] busreq;
  logic [3:0] bus_addr;
  logic [3:0] bus_wdata;
  logic [3:0] bus_rdata;
  logic       bus_ack;
  modport master (
    output instr, instr_valid, bus_rdata, bus_ack,
    input  instr_ready, busreq, bus_addr, bus_wdata
  );
  modport slave (
    input  instr, instr_valid, bus_rdata, bus_ack,
    output instr_ready, busreq, bus_addr, bus_wdata
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: 4-bit sequential accumulator ALU fetching operands over a register bus.
//   clk, rst_n (async active-low), ena (low freezes all state),
//   bus (alu_seq_if.slave: instr/instr_valid/instr_ready, busreq/bus_addr/bus_wdata/bus_rdata/bus_ack),
//   acc, carry, done (one-cycle retire pulse), err (sticky bus timeout).
//   Define BUSREQ_TIMEOUT_EN to abort RD/WR after 8 cycles without ack; otherwise err is always 0.
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  alu_seq_if.slave   bus,
  output logic [3:0] acc,
  output logic       carry,
  output logic       done,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, RD, EXEC, WR} state_t;
  state_t     state_q, state_d;
  logic [3:0] op_q, op_d, idx_q, idx_d, opnd_q, opnd_d, acc_q, acc_d;
  logic       carry_q, carry_d, done_q, done_d, err_q, err_d;
  logic [4:0] sum;
  logic       arith;
`ifdef BUSREQ_TIMEOUT_EN
  logic [2:0] cnt_q, cnt_d;
`endif
  // bit 4 of the 5-bit result is carry for add and borrow for sub
  assign sum   = op_q == 4'd3 ? {1'b0, acc_q} - {1'b0, opnd_q}
                              : {1'b0, acc_q} + {1'b0, op_q == 4'd1 ? idx_q : opnd_q};
  assign arith = op_q inside {4'd1, 4'd2, 4'd3};
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    err_d   = err_q;
    done_d  = 1'b0;
`ifdef BUSREQ_TIMEOUT_EN
    cnt_d   = 3'd0;
`endif
    case (state_q)
      IDLE: if (bus.instr_valid) begin
        op_d    = bus.instr[3:0];
        idx_d   = bus.instr[7:4];
        state_d = bus.instr[3:0] inside {4'd2, 4'd3, 4'd4} ? RD : bus.instr[3:0] == 4'd5 ? WR : EXEC;
      end
      EXEC: begin
        {carry_d, acc_d} = arith ? sum : {carry_q, op_q == 4'd4 ? acc_q & opnd_q : op_q == 4'd6 ? idx_q : acc_q};
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: if (bus.bus_ack) begin
        opnd_d  = state_q == RD ? bus.bus_rdata : opnd_q;
        state_d = state_q == RD ? EXEC : IDLE;
        done_d  = state_q == WR;
      end
`ifdef BUSREQ_TIMEOUT_EN
      else if (cnt_q == 3'd7) begin
        state_d = IDLE;
        err_d   = 1'b1;
        done_d  = 1'b1;
      end else cnt_d = cnt_q + 3'd1;
`endif
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      idx_q   <= 4'd0;
      opnd_q  <= 4'd0;
      acc_q   <= 4'd0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BUSREQ_TIMEOUT_EN
      cnt_q   <= 3'd0;
`endif
    end else if (ena) begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef BUSREQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  assign bus.instr_ready = state_q == IDLE;
  assign bus.busreq      = state_q == RD ? 4'b0001 : state_q == WR ? 4'b0101 : 4'b0000;
  assign bus.bus_addr    = idx_q;
  assign bus.bus_wdata   = state_q == WR ? acc_q : 4'd0;
  assign acc             = acc_q;
  assign carry           = carry_q;
  assign done            = done_q;
  assign err             = err_q;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port ena  input  1  design select; low freezes all state except reset.
REQ-004 SHALL have port instr  input  8  instruction; [3:0] opcode, [7:4] imm/register index.
REQ-005 SHALL have port instr_valid  input  1  instr is presented.
REQ-006 SHALL have port instr_ready  output  1  high only in IDLE; accept = instr_valid & instr_ready & ena.
REQ-007 SHALL have port busreq  output  4  bus request code: 0000 idle, 0001 read register, 0101 write register.
REQ-008 SHALL have port bus_addr  output  4  register index of current request.
REQ-009 SHALL have port bus_wdata  output  4  write data, valid while busreq=0101.
REQ-010 SHALL have port bus_rdata  input  4  register value returned by register block.
REQ-011 SHALL have port bus_ack  input  1  register block completes current request.
REQ-012 SHALL have port acc  output  4  accumulator (ALU result).
REQ-013 SHALL have port carry  output  1  carry/borrow of last arithmetic op.
REQ-014 SHALL have port done  output  1  one-cycle pulse when instruction retires.
REQ-015 SHALL have port err  output  1  sticky bus-timeout flag (see Configuration).

Function
REQ-016 SHALL implement states IDLE, RD, EXEC, WR.
REQ-017 Opcodes SHALL be: 0000 NOP, 0001 ADDI, 0010 ADD, 0011 SUB, 0100 AND, 0101 STORE, 0110 LDI; others execute as NOP.
REQ-018 On accept, SHALL latch opcode and index; ADD/SUB/AND go to RD, STORE to WR, all others to EXEC.
REQ-019 RD SHALL drive busreq=0001, bus_addr=index, holding both stable until the edge where bus_ack=1, then latch bus_rdata as operand and go to EXEC.
REQ-020 WR SHALL drive busreq=0101, bus_addr=index, bus_wdata=acc, held until the edge where bus_ack=1, then go to IDLE with done.
REQ-021 EXEC SHALL last one cycle, update acc/carry, return to IDLE and pulse done in the following cycle.
REQ-022 Arithmetic SHALL be modulo 16: ADDI acc+imm, ADD acc+operand (carry = bit 4), SUB acc-operand (carry = borrow), AND acc&operand (carry unchanged), LDI acc=imm (carry unchanged), NOP no change.
REQ-023 bus_ack outside RD/WR SHALL be ignored; busreq SHALL be 0000 in IDLE and EXEC.
REQ-024 Latency: ADDI/LDI/NOP retire 2 edges after accept; ADD/SUB/AND retire 2 edges after ack edge; STORE done the cycle after ack edge.
REQ-025 ena=0 SHALL hold state, outputs and timeout counter; done SHALL not pulse twice for one instruction.
REQ-026 instr changes while not in IDLE SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, acc=0, carry=0, done=0, err=0, busreq=0000, bus_addr=0, bus_wdata=0, instr_ready=1 after release.
REQ-028 Reset mid RD/WR SHALL abandon the request; no write and no acc update occur.

Configuration
REQ-029 With BUSREQ_TIMEOUT_EN defined, a 3-bit counter SHALL count cycles in RD/WR; at 8 cycles without ack, SHALL set err=1, leave acc unchanged, go to IDLE and pulse done.
REQ-030 Without BUSREQ_TIMEOUT_EN, RD/WR SHALL wait indefinitely and err SHALL be constant 0.

Verification
REQ-031 Reset, accept LDI imm=5, then ADDI imm=2 -> acc=7, carry=0, done pulses once per instruction, ADDI retiring 2 edges after accept.
REQ-032 acc=6, ADD index=1, ack after 3 cycles with bus_rdata=4 -> busreq=0001 & bus_addr=1 stable 3 cycles, acc=10, carry=0.
REQ-033 acc=3, SUB with bus_rdata=5 -> acc=14, carry=1; acc=15, ADDI 1 -> acc=0, carry=1.
REQ-034 acc=9, STORE index=2 -> busreq=0101, bus_addr=2, bus_wdata=9 until ack; done next cycle; acc unchanged.
REQ-035 BUSREQ_TIMEOUT_EN on, ADD with no ack -> after 8 cycles err=1, state IDLE, acc unchanged; off -> still RD after 20 cycles.
REQ-036 rst_n pulsed low during RD with ack never given -> busreq=0000 and acc=0 immediately, instr_ready=1 after release.
